// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/subtract, carry chain cut into
// STAGE_BITS segments, one register stage each. Option: RS_ADDER_OVERFLOW_EN
module pipelined_carry_adder #(
  parameter int WIDTH      = 32,
  parameter int STAGE_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef RS_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             cout
);

  localparam int NS = (WIDTH + STAGE_BITS - 1) / STAGE_BITS;

  logic             vld_q [NS];
  logic             vld_d [NS];
  logic [WIDTH-1:0] sum_q [NS];
  logic [WIDTH-1:0] sum_d [NS];
  logic [WIDTH-1:0] p_q   [NS];
  logic [WIDTH-1:0] p_d   [NS];
  logic [WIDTH-1:0] g_q   [NS];
  logic [WIDTH-1:0] g_d   [NS];
  logic             c_q   [NS];
  logic             c_d   [NS];

  logic             vin   [NS];
  logic [WIDTH-1:0] sin   [NS];
  logic [WIDTH-1:0] pin   [NS];
  logic [WIDTH-1:0] gin   [NS];
  logic             cin_s [NS];

  logic [WIDTH-1:0] bb;
  logic             stall;

`ifdef RS_ADDER_OVERFLOW_EN
  logic             c_msb;
  logic             ovf_d;
  logic             ovf_q;
  assign overflow = ovf_q;
`endif

  assign out_valid = vld_q[NS-1];
  assign sum       = sum_q[NS-1];
  assign cout      = c_q[NS-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign bb        = b ^ {WIDTH{sub}};

  // Stage inputs: stage 0 from the ports, later stages from prior register
  always_comb begin
    vin[0]   = in_valid;
    sin[0]   = '0;
    pin[0]   = a ^ bb;
    gin[0]   = a & bb;
    cin_s[0] = sub | cin;
    for (int k = 1; k < NS; k++) begin
      vin[k]   = vld_q[k-1];
      sin[k]   = sum_q[k-1];
      pin[k]   = p_q[k-1];
      gin[k]   = g_q[k-1];
      cin_s[k] = c_q[k-1];
    end
  end

  // Each stage ripples its own bit slice and passes upper p/g untouched
  always_comb begin
    logic c;
    c = 1'b0;
`ifdef RS_ADDER_OVERFLOW_EN
    c_msb = 1'b0;
`endif
    for (int k = 0; k < NS; k++) begin
      c        = cin_s[k];
      sum_d[k] = sin[k];
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= k * STAGE_BITS && i < (k + 1) * STAGE_BITS) begin
`ifdef RS_ADDER_OVERFLOW_EN
          if (i == WIDTH - 1) c_msb = c;
`endif
          sum_d[k][i] = pin[k][i] ^ c;
          c = pin[k][i] ? c : gin[k][i];
        end
      end
      vld_d[k] = vin[k];
      p_d[k]   = pin[k];
      g_d[k]   = gin[k];
      c_d[k]   = c;
    end
`ifdef RS_ADDER_OVERFLOW_EN
    ovf_d = c_d[NS-1] ^ c_msb;
`endif
  end

  // Pipeline registers: global hold on output stall, async clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= 1'b0;
        sum_q[k] <= '0;
        p_q[k]   <= '0;
        g_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
`ifdef RS_ADDER_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else if (!stall) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= vld_d[k];
        sum_q[k] <= sum_d[k];
        p_q[k]   <= p_d[k];
        g_q[k]   <= g_d[k];
        c_q[k]   <= c_d[k];
      end
`ifdef RS_ADDER_OVERFLOW_EN
      ovf_q <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: directed and randomized checks of the
// pipelined adder in 8/4, 32/32 and 5/2 configurations.
module tb_pipelined_carry_adder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic       v8, ir8, sub8, cin8, ov8, rdy8, cout8;
  logic [7:0] a8, b8, sum8;
  logic        v32, ir32, sub32, cin32, ov32, rdy32, cout32;
  logic [31:0] a32, b32, sum32;
  logic       v5, ir5, sub5, cin5, ov5, rdy5, cout5;
  logic [4:0] a5, b5, sum5;
`ifdef RS_ADDER_OVERFLOW_EN
  logic ovf8, ovf32, ovf5;
`endif

  typedef struct {
    longint unsigned s;
    bit              c;
    bit              o;
  } exp_t;

  pipelined_carry_adder #(.WIDTH(8), .STAGE_BITS(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8),
    .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(rdy8), .sum(sum8),
`ifdef RS_ADDER_OVERFLOW_EN
    .overflow(ovf8),
`endif
    .cout(cout8)
  );

  pipelined_carry_adder #(.WIDTH(32), .STAGE_BITS(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32),
    .sub(sub32), .a(a32), .b(b32), .cin(cin32),
    .out_valid(ov32), .out_ready(rdy32), .sum(sum32),
`ifdef RS_ADDER_OVERFLOW_EN
    .overflow(ovf32),
`endif
    .cout(cout32)
  );

  pipelined_carry_adder #(.WIDTH(5), .STAGE_BITS(2)) u5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(ir5),
    .sub(sub5), .a(a5), .b(b5), .cin(cin5),
    .out_valid(ov5), .out_ready(rdy5), .sum(sum5),
`ifdef RS_ADDER_OVERFLOW_EN
    .overflow(ovf5),
`endif
    .cout(cout5)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_model(input int w,
                                     input longint unsigned x,
                                     input longint unsigned y,
                                     input bit c, input bit s);
    exp_t            e;
    longint unsigned m, t;
    longint          sx, sy, sr, half;
    m    = 64'd1 << w;
    half = longint'(m / 2);
    sx   = (x >= m / 2) ? longint'(x) - longint'(m) : longint'(x);
    sy   = (y >= m / 2) ? longint'(y) - longint'(m) : longint'(y);
    if (s) begin
      e.s = (x + m - y) % m;
      e.c = (x >= y);
      sr  = sx - sy;
    end else begin
      t   = x + y + longint'(c);
      e.s = t % m;
      e.c = (t >= m);
      sr  = sx + sy + longint'(c);
    end
    e.o = (sr >= half) || (sr < -half);
    return e;
  endfunction

  task automatic send8(input logic [7:0] av, input logic [7:0] bv,
                       input logic c, input logic s,
                       output int lat);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = c; sub8 = s;
    v8 = 1'b1; rdy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8  = 1'b0;
    lat = 1;
    while (!ov8 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ov8 !== 1'b0)
      $display("FAIL reset_out_valid: got %b want 0", ov8);
    if (ov8 !== 1'b0) errors++;
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      $display("FAIL reset_data: got %h/%b want 00/0", sum8, cout8);
      errors++;
    end
    checks++;
    if (ov32 !== 1'b0 || ov5 !== 1'b0 || sum5 !== 5'd0) begin
      $display("FAIL reset_others: got %b %b %h want 0 0 00",
               ov32, ov5, sum5);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ir8 !== 1'b1 || ir32 !== 1'b1 || ir5 !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b%b%b want 111",
               ir8, ir32, ir5);
      errors++;
    end
  endtask

  task automatic test_add();
    int lat;
    send8(8'h3C, 8'h45, 1'b1, 1'b0, lat);
    checks++;
    if (lat != 2) begin
      $display("FAIL add_latency: got %0d want 2", lat);
      errors++;
    end
    checks++;
    if (sum8 !== 8'h82 || cout8 !== 1'b0) begin
      $display("FAIL add_result: got %h/%b want 82/0", sum8, cout8);
      errors++;
    end
`ifdef RS_ADDER_OVERFLOW_EN
    checks++;
    if (ovf8 !== 1'b1) begin
      $display("FAIL add_overflow: got %b want 1", ovf8);
      errors++;
    end
`endif
  endtask

  task automatic test_wrap();
    int lat;
    send8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 2 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
      $display("FAIL wrap: got lat %0d %h/%b want lat 2 00/1",
               lat, sum8, cout8);
      errors++;
    end
`ifdef RS_ADDER_OVERFLOW_EN
    checks++;
    if (ovf8 !== 1'b0) begin
      $display("FAIL wrap_overflow: got %b want 0", ovf8);
      errors++;
    end
`endif
  endtask

  task automatic test_sub();
    int lat;
    send8(8'h10, 8'h20, 1'b1, 1'b1, lat);
    checks++;
    if (sum8 !== 8'hF0 || cout8 !== 1'b0) begin
      $display("FAIL sub_borrow: got %h/%b want F0/0", sum8, cout8);
      errors++;
    end
`ifdef RS_ADDER_OVERFLOW_EN
    checks++;
    if (ovf8 !== 1'b0) begin
      $display("FAIL sub_borrow_ovf: got %b want 0", ovf8);
      errors++;
    end
`endif
    send8(8'h20, 8'h10, 1'b0, 1'b1, lat);
    checks++;
    if (sum8 !== 8'h10 || cout8 !== 1'b1) begin
      $display("FAIL sub_noborrow: got %h/%b want 10/1", sum8, cout8);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    exp_t       q[$];
    exp_t       e;
    logic [8:0] held;
    bit         was_stall;
    int         sent, got, cyc, stalls;
    ta = '{8'h11, 8'hF0, 8'h7F, 8'h80};
    tb = '{8'h22, 8'h20, 8'h01, 8'h80};
    was_stall = 1'b0;
    sent = 0; got = 0; cyc = 0; stalls = 0; held = '0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      v8 = (sent < 4);
      if (sent < 4) begin
        a8 = ta[sent]; b8 = tb[sent]; cin8 = 1'b0; sub8 = 1'b0;
      end
      rdy8 = !(cyc >= 3 && cyc < 6);
      #1;
      if (was_stall) begin
        checks++;
        if (ov8 !== 1'b1 || {cout8, sum8} !== held) begin
          $display("FAIL b2b_hold: got %b %h want 1 %h",
                   ov8, {cout8, sum8}, held);
          errors++;
        end
      end
      if (ov8 && !rdy8) begin
        stalls++;
        checks++;
        if (ir8 !== 1'b0) begin
          $display("FAIL b2b_in_ready: got %b want 0", ir8);
          errors++;
        end
      end
      if (ov8 && rdy8) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL b2b_extra: got %h want none", sum8);
          errors++;
        end else begin
          e = q.pop_front();
          if (sum8 !== e.s[7:0] || cout8 !== e.c) begin
            $display("FAIL b2b_order %0d: got %h/%b want %h/%b",
                     got, sum8, cout8, e.s[7:0], e.c);
            errors++;
          end
        end
        got++;
      end
      if (v8 && ir8) begin
        q.push_back(ref_model(8, longint'(a8), longint'(b8),
                              1'b0, 1'b0));
        sent++;
      end
      was_stall = ov8 && !rdy8;
      held = {cout8, sum8};
      cyc++;
    end
    @(negedge clk);
    v8 = 1'b0; rdy8 = 1'b1;
    checks++;
    if (got != 4 || sent != 4 || q.size() != 0) begin
      $display("FAIL b2b_count: got %0d/%0d left %0d want 4/4 left 0",
               sent, got, q.size());
      errors++;
    end
    checks++;
    if (stalls != 3) begin
      $display("FAIL b2b_stalls: got %0d want 3", stalls);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    int stale;
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h45; cin8 = 1'b0; sub8 = 1'b0;
    v8 = 1'b1; rdy8 = 1'b1;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02;
    @(negedge clk);
    v8 = 1'b0; rdy8 = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b1 || sum8 !== 8'h81) begin
      $display("FAIL arst_pre: got %b %h want 1 81", ov8, sum8);
      errors++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ov8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      $display("FAIL arst_clear: got %b %h %b want 0 00 0",
               ov8, sum8, cout8);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0; rdy8 = 1'b1;
    #1;
    checks++;
    if (ir8 !== 1'b1) begin
      $display("FAIL arst_in_ready: got %b want 1", ir8);
      errors++;
    end
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov8 !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      $display("FAIL arst_stale: got %0d want 0", stale);
      errors++;
    end
  endtask

  task automatic test_random();
    exp_t q32[$];
    exp_t q5[$];
    exp_t e;
    int   n32i, n32o, n5i, n5o, cyc;
    bit   nx32, nx5;
    n32i = 0; n32o = 0; n5i = 0; n5o = 0; cyc = 0;
    nx32 = 1'b1; nx5 = 1'b1;
    while ((n32o < 1000 || n5o < 1000) && cyc < 20000) begin
      @(negedge clk);
      if (nx32) begin
        v32 = (n32i < 1000) && ($urandom_range(0, 3) != 0);
        a32 = $urandom; b32 = $urandom;
        cin32 = 1'($urandom_range(0, 1));
        sub32 = 1'($urandom_range(0, 1));
      end
      if (nx5) begin
        v5 = (n5i < 1000) && ($urandom_range(0, 3) != 0);
        a5 = 5'($urandom); b5 = 5'($urandom);
        cin5 = 1'($urandom_range(0, 1));
        sub5 = 1'($urandom_range(0, 1));
      end
      rdy32 = ($urandom_range(0, 3) != 0);
      rdy5  = ($urandom_range(0, 3) != 0);
      #1;
      if (ov32 && rdy32) begin
        checks++;
        if (q32.size() == 0) begin
          $display("FAIL rnd32_extra: got %h want none", sum32);
          errors++;
        end else begin
          e = q32.pop_front();
          if (sum32 !== e.s[31:0] || cout32 !== e.c
`ifdef RS_ADDER_OVERFLOW_EN
              || ovf32 !== e.o
`endif
             ) begin
            $display("FAIL rnd32 #%0d: got %h/%b want %h/%b",
                     n32o, sum32, cout32, e.s[31:0], e.c);
            errors++;
          end
        end
        n32o++;
      end
      if (ov5 && rdy5) begin
        checks++;
        if (q5.size() == 0) begin
          $display("FAIL rnd5_extra: got %h want none", sum5);
          errors++;
        end else begin
          e = q5.pop_front();
          if (sum5 !== e.s[4:0] || cout5 !== e.c
`ifdef RS_ADDER_OVERFLOW_EN
              || ovf5 !== e.o
`endif
             ) begin
            $display("FAIL rnd5 #%0d: got %h/%b want %h/%b",
                     n5o, sum5, cout5, e.s[4:0], e.c);
            errors++;
          end
        end
        n5o++;
      end
      if (v32 && ir32) begin
        q32.push_back(ref_model(32, longint'(a32), longint'(b32),
                                cin32, sub32));
        n32i++;
      end
      if (v5 && ir5) begin
        q5.push_back(ref_model(5, longint'(a5), longint'(b5),
                               cin5, sub5));
        n5i++;
      end
      nx32 = !v32 || ir32;
      nx5  = !v5 || ir5;
      cyc++;
    end
    @(negedge clk);
    v32 = 1'b0; v5 = 1'b0;
    checks++;
    if (n32o != 1000 || n5o != 1000) begin
      $display("FAIL rnd_timeout: got %0d/%0d want 1000/1000",
               n32o, n5o);
      errors++;
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    clk = 1'b0; rst = 1'b1;
    v8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0; rdy8 = 1;
    v32 = 0; sub32 = 0; cin32 = 0; a32 = '0; b32 = '0; rdy32 = 1;
    v5 = 0; sub5 = 0; cin5 = 0; a5 = '0; b5 = '0; rdy5 = 1;
    test_reset();
    test_add();
    test_wrap();
    test_sub();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
